// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative divider.
// Imported by the interface, the step cell and the top.
package div_pkg;

  localparam int DIV_W    = 32;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    RST_WAIT,
    IDLE,
    CALC,
    DONE
  } div_state_e;

  function automatic logic [DIV_W-1:0] mag(
    input logic [DIV_W-1:0] x,
    input logic             sgn
  );
    return (sgn && x[DIV_W-1]) ? -x : x;
  endfunction

  function automatic logic [DIV_W-1:0] neg_if(
    input logic [DIV_W-1:0] x,
    input logic             neg
  );
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/iter_div_if.sv
// Divisor/dividend valid-ready sources and the result pulse.
// EX is the master side, the divider the slave side.
interface iter_div_if;
  import div_pkg::*;

  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [DIV_W-1:0]   s_axis_divisor_tdata;
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [DIV_W-1:0]   s_axis_dividend_tdata;
  logic               m_axis_dout_tvalid;
  logic [2*DIV_W-1:0] m_axis_dout_tdata;

  modport master (
    output s_axis_divisor_tvalid,
    output s_axis_divisor_tdata,
    output s_axis_dividend_tvalid,
    output s_axis_dividend_tdata,
    input  s_axis_divisor_tready,
    input  s_axis_dividend_tready,
    input  m_axis_dout_tvalid,
    input  m_axis_dout_tdata
  );

  modport slave (
    input  s_axis_divisor_tvalid,
    input  s_axis_divisor_tdata,
    input  s_axis_dividend_tvalid,
    input  s_axis_dividend_tdata,
    output s_axis_divisor_tready,
    output s_axis_dividend_tready,
    output m_axis_dout_tvalid,
    output m_axis_dout_tdata
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift, 33-bit trial subtract, select.
// Remainder MSB shifted out is kept in the trial so big divisors work.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem,
  input  logic [DIV_W-1:0] quo,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_nxt,
  output logic [DIV_W-1:0] quo_nxt
);

  logic [DIV_W:0] wide;
  logic [DIV_W:0] trial;

  always_comb begin
    wide  = {rem, quo[DIV_W-1]};
    trial = wide - {1'b0, divisor};
    quo_nxt = {quo[DIV_W-2:0], ~trial[DIV_W]};
    if (!trial[DIV_W]) begin
      rem_nxt = trial[DIV_W-1:0];
    end else begin
      rem_nxt = wide[DIV_W-1:0];
    end
  end

endmodule

// File: rtl/iter_div.sv
// Multi-cycle radix-2 restoring divider, 34 cycles per operation.
// SIGNED selects two's-complement div/mod or unsigned.
module iter_div
  import div_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input logic        clk,
  input logic        resetn,
  iter_div_if.slave  bus
);

  div_state_e         state_q;
  div_state_e         state_n;
  logic [CNT_W-1:0]   cnt_q;
  logic [DIV_W-1:0]   rem_q;
  logic [DIV_W-1:0]   quo_q;
  logic [DIV_W-1:0]   dvs_q;
  logic [DIV_W-1:0]   rem_n;
  logic [DIV_W-1:0]   quo_n;
  logic               q_neg;
  logic               r_neg;
  logic               rdy_q;
  logic               vld_q;
  logic [2*DIV_W-1:0] dout_q;
  logic               accept;
  logic               last;
  logic [DIV_W-1:0]   dvd;
  logic [DIV_W-1:0]   dvs;

  assign dvd = bus.s_axis_dividend_tdata;
  assign dvs = bus.s_axis_divisor_tdata;

  assign accept = (state_q == IDLE)
                & bus.s_axis_divisor_tvalid
                & bus.s_axis_dividend_tvalid;
  assign last = (cnt_q == CNT_W'(DIV_ITER - 1));

  assign bus.s_axis_divisor_tready  = rdy_q;
  assign bus.s_axis_dividend_tready = rdy_q;
  assign bus.m_axis_dout_tvalid     = vld_q;
  assign bus.m_axis_dout_tdata      = dout_q;

  div_step u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_n),
    .quo_nxt (quo_n)
  );

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      RST_WAIT: state_n = IDLE;
      IDLE:     if (accept) state_n = CALC;
      CALC:     if (last) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = RST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RST_WAIT;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_n;
      rdy_q   <= (state_n == IDLE);
      vld_q   <= (state_n == DONE);
      if (accept) begin
        rem_q <= '0;
        quo_q <= mag(dvd, SIGNED);
        dvs_q <= mag(dvs, SIGNED);
        q_neg <= SIGNED & (dvd[DIV_W-1] ^ dvs[DIV_W-1]);
        r_neg <= SIGNED & dvd[DIV_W-1];
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q + CNT_W'(1);
        // result register is loaded straight from the final step
        if (last) begin
          dout_q <= {neg_if(quo_n, q_neg), neg_if(rem_n, r_neg)};
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Directed bench: signed and unsigned copies share one stimulus.
// Expected results are hand-computed constants.
module tb_iter_div;

  logic        clk;
  logic        resetn;
  logic        dvs_v;
  logic        dvd_v;
  logic [31:0] dvs_d;
  logic [31:0] dvd_d;

  int checks;
  int failures;

  iter_div_if ifs ();
  iter_div_if ifu ();

  assign ifs.s_axis_divisor_tvalid  = dvs_v;
  assign ifs.s_axis_divisor_tdata   = dvs_d;
  assign ifs.s_axis_dividend_tvalid = dvd_v;
  assign ifs.s_axis_dividend_tdata  = dvd_d;
  assign ifu.s_axis_divisor_tvalid  = dvs_v;
  assign ifu.s_axis_divisor_tdata   = dvs_d;
  assign ifu.s_axis_dividend_tvalid = dvd_v;
  assign ifu.s_axis_dividend_tdata  = dvd_d;

  iter_div #(.SIGNED(1'b1)) u_s (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifs.slave)
  );

  iter_div #(.SIGNED(1'b0)) u_u (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifu.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hs();
    return {60'd0,
            ifs.s_axis_divisor_tready, ifs.s_axis_dividend_tready,
            ifu.s_axis_divisor_tready, ifu.s_axis_dividend_tready};
  endfunction

  function automatic logic [63:0] vl();
    return {62'd0, ifs.m_axis_dout_tvalid, ifu.m_axis_dout_tvalid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after an edge with tready high.
  task automatic run_op(
    input string       tag,
    input logic [31:0] dvd,
    input logic [31:0] dvs,
    input logic [63:0] exp_s,
    input logic [63:0] exp_u
  );
    int bad;
    bad = 0;
    dvd_d = dvd;
    dvs_d = dvs;
    dvd_v = 1'b1;
    dvs_v = 1'b1;
    tick();
    dvd_v = 1'b0;
    dvs_v = 1'b0;
    check({tag, "_acc"}, hs(), 64'd0);
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k == 3) begin
        dvd_d = 32'hDEAD_BEEF;
        dvs_d = 32'h0000_0003;
      end
      if (k == 32) begin
        check({tag, "_s"}, ifs.m_axis_dout_tdata, exp_s);
        check({tag, "_u"}, ifu.m_axis_dout_tdata, exp_u);
        check({tag, "_vld"}, vl(), 64'h3);
        check({tag, "_rdy32"}, hs(), 64'd0);
      end else if (k == 33) begin
        check({tag, "_rdy34"}, hs(), 64'hF);
        check({tag, "_vld34"}, vl(), 64'd0);
        check({tag, "_hold"}, ifs.m_axis_dout_tdata, exp_s);
      end else if ((vl() != 0) || (hs() != 0)) begin
        bad++;
      end
    end
    check({tag, "_calc"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int bad;
    int npulse;
    int p1;
    int p2;
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    dvs_v    = 1'b0;
    dvd_v    = 1'b0;
    dvs_d    = '0;
    dvd_d    = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rdy", hs(), 64'd0);
      check("rst_vld", vl(), 64'd0);
      check("rst_dout",
            ifs.m_axis_dout_tdata | ifu.m_axis_dout_tdata, 64'd0);
    end
    resetn = 1'b1;
    #1;
    check("rel_rdy", hs(), 64'd0);
    tick();
    check("rel_rdy1", hs(), 64'hF);
    check("rel_vld", vl(), 64'd0);

    // divisor alone must not start anything
    bad = 0;
    dvs_v = 1'b1;
    dvs_d = 32'd7;
    dvd_d = 32'd100;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ((hs() != 64'hF) || (vl() != 0)) bad++;
    end
    check("one_vld", 64'(bad), 64'd0);

    run_op("u100_7", 32'd100, 32'd7,
           64'h0000000E_00000002, 64'h0000000E_00000002);
    run_op("m7_2", 32'hFFFF_FFF9, 32'd2,
           64'hFFFFFFFD_FFFFFFFF, 64'h7FFFFFFC_00000001);
    run_op("p7_m2", 32'd7, 32'hFFFF_FFFE,
           64'hFFFFFFFD_00000001, 64'h00000000_00000007);
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF,
           64'h80000000_00000000, 64'h00000000_80000000);
    run_op("dz", 32'h1234_5678, 32'd0,
           64'hFFFFFFFF_12345678, 64'hFFFFFFFF_12345678);

    // abort in the middle of an operation
    dvd_d = 32'd1000;
    dvs_d = 32'd7;
    dvd_v = 1'b1;
    dvs_v = 1'b1;
    tick();
    dvd_v = 1'b0;
    dvs_v = 1'b0;
    repeat (9) tick();
    resetn = 1'b0;
    #1;
    check("abt_rdy", hs(), 64'd0);
    check("abt_vld", vl(), 64'd0);
    check("abt_dout",
          ifs.m_axis_dout_tdata | ifu.m_axis_dout_tdata, 64'd0);
    repeat (2) tick();
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (vl() != 0) bad++;
    end
    check("abt_nopulse", 64'(bad), 64'd0);
    check("abt_rdy1", hs(), 64'hF);

    // back-to-back with valids held high
    npulse = 0;
    p1 = -1;
    p2 = -1;
    dvd_d = 32'd1000;
    dvs_d = 32'd7;
    dvd_v = 1'b1;
    dvs_v = 1'b1;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (k == 67) begin
        dvd_v = 1'b0;
        dvs_v = 1'b0;
      end
      if (ifs.m_axis_dout_tvalid) begin
        npulse++;
        if (npulse == 1) p1 = k;
        if (npulse == 2) p2 = k;
        check("b2b_s", ifs.m_axis_dout_tdata, 64'h0000008E_00000006);
        check("b2b_u", ifu.m_axis_dout_tdata, 64'h0000008E_00000006);
      end
    end
    check("b2b_n", 64'(npulse), 64'd2);
    check("b2b_p1", 64'(p1), 64'd32);
    check("b2b_p2", 64'(p2), 64'd66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
